// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Forwarding select encodings and the memory-wait FSM states live here.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one EX-stage source operand.
// MEM is the younger producer, so it wins over WB; x0 is never forwarded.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_reg_wr_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_wr_w,
  output fwd_sel_t          o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_reg_wr_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
  assign w_hit_w = i_reg_wr_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m)      o_sel = FWD_MEM;
    else if (w_hit_w) o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage RV32I pipeline.
// Priority: memory wait, then redirect (live or held), then load-use.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic              i_reg_wr_e,
  input  logic              i_mem_rd_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_wr_m,
  input  logic              i_reg_wr_w,
  input  logic              i_branch_taken_e,
  input  logic              i_dmem_req_m,
  input  logic              i_dmem_ready,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_flush_d,
  output logic              o_stall_e,
  output logic              o_stall_m,
  output logic              o_flush_e,
  output logic              o_flush_w,
  output logic              o_redirect_ok,
  output logic [1:0]        o_fwd_a_e,
  output logic [1:0]        o_fwd_b_e,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  hz_state_t        r_state;
  logic             r_pend_redir;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_mem_wait;
  logic     w_redirect;
  logic     w_load_use;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs_e(i_rs1_e), .i_rd_m(i_rd_m), .i_reg_wr_m(i_reg_wr_m),
    .i_rd_w(i_rd_w), .i_reg_wr_w(i_reg_wr_w), .o_sel(w_fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs_e(i_rs2_e), .i_rd_m(i_rd_m), .i_reg_wr_m(i_reg_wr_m),
    .i_rd_w(i_rd_w), .i_reg_wr_w(i_reg_wr_w), .o_sel(w_fwd_b)
  );

  assign o_fwd_a_e = rst ? FWD_RF : w_fwd_a;
  assign o_fwd_b_e = rst ? FWD_RF : w_fwd_b;

  assign w_mem_wait = ((r_state == RUN) && i_dmem_req_m && !i_dmem_ready) ||
                      ((r_state == MEM_WAIT) && !i_dmem_ready);
  assign w_redirect = !w_mem_wait && (i_branch_taken_e || r_pend_redir);
  assign w_load_use = i_mem_rd_e && i_reg_wr_e && (i_rd_e != '0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

  always_comb begin
    o_stall_f     = 1'b0;
    o_stall_d     = 1'b0;
    o_stall_e     = 1'b0;
    o_stall_m     = 1'b0;
    o_flush_d     = 1'b0;
    o_flush_e     = 1'b0;
    o_flush_w     = 1'b0;
    o_redirect_ok = 1'b0;
    if (!rst) begin
      if (w_mem_wait) begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_stall_e = 1'b1;
        o_stall_m = 1'b1;
        o_flush_w = 1'b1;
      end else if (w_redirect) begin
        // A load-use consumer behind a taken branch is on the wrong path anyway.
        o_flush_d     = 1'b1;
        o_flush_e     = 1'b1;
        o_redirect_ok = 1'b1;
      end else if (w_load_use) begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_flush_e = 1'b1;
      end else begin
        o_redirect_ok = i_branch_taken_e;
      end
    end
  end

  // A branch seen while EX is frozen is remembered until the wait ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_pend_redir <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      case (r_state)
        RUN:      if (i_dmem_req_m && !i_dmem_ready) r_state <= MEM_WAIT;
        MEM_WAIT: if (i_dmem_ready) r_state <= RUN;
        default:  r_state <= RUN;
      endcase
      if (w_mem_wait) begin
        if (i_branch_taken_e) r_pend_redir <= 1'b1;
      end else begin
        r_pend_redir <= 1'b0;
      end
      if (o_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (o_flush_d && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Control outputs are checked as one 8-bit bundle: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,redirect_ok}.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W  = 16;
  localparam int REG_AW = 5;

  localparam logic [7:0] CTL_IDLE  = 8'b0000_0000;
  localparam logic [7:0] CTL_LU    = 8'b1100_0100;
  localparam logic [7:0] CTL_REDIR = 8'b0000_1101;
  localparam logic [7:0] CTL_WAIT  = 8'b1111_0010;
  localparam logic [7:0] CTL_BROK  = 8'b0000_0001;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w;
  logic              i_reg_wr_e, i_mem_rd_e, i_reg_wr_m, i_reg_wr_w;
  logic              i_branch_taken_e, i_dmem_req_m, i_dmem_ready;
  logic              o_stall_f, o_stall_d, o_flush_d, o_stall_e, o_stall_m;
  logic              o_flush_e, o_flush_w, o_redirect_ok;
  logic [1:0]        o_fwd_a_e, o_fwd_b_e;
  logic [CNT_W-1:0]  o_stall_cnt, o_flush_cnt;
  logic [7:0]        ctl;

  int vectors     = 0;
  int miscompares = 0;
  int expStall    = 0;
  int expFlush    = 0;

  assign ctl = {o_stall_f, o_stall_d, o_stall_e, o_stall_m,
                o_flush_d, o_flush_e, o_flush_w, o_redirect_ok};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d), .i_rs1_e(i_rs1_e), .i_rs2_e(i_rs2_e),
    .i_rd_e(i_rd_e), .i_reg_wr_e(i_reg_wr_e), .i_mem_rd_e(i_mem_rd_e),
    .i_rd_m(i_rd_m), .i_rd_w(i_rd_w), .i_reg_wr_m(i_reg_wr_m), .i_reg_wr_w(i_reg_wr_w),
    .i_branch_taken_e(i_branch_taken_e), .i_dmem_req_m(i_dmem_req_m),
    .i_dmem_ready(i_dmem_ready),
    .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_flush_d(o_flush_d),
    .o_stall_e(o_stall_e), .o_stall_m(o_stall_m), .o_flush_e(o_flush_e),
    .o_flush_w(o_flush_w), .o_redirect_ok(o_redirect_ok),
    .o_fwd_a_e(o_fwd_a_e), .o_fwd_b_e(o_fwd_b_e),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  task automatic idle_inputs();
    i_rs1_d = '0; i_rs2_d = '0; i_rs1_e = '0; i_rs2_e = '0;
    i_rd_e = '0; i_rd_m = '0; i_rd_w = '0;
    i_reg_wr_e = 1'b0; i_mem_rd_e = 1'b0; i_reg_wr_m = 1'b0; i_reg_wr_w = 1'b0;
    i_branch_taken_e = 1'b0; i_dmem_req_m = 1'b0; i_dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    i_dmem_req_m = 1'b1;
    tick(); tick();
    vectors++;
    if (o_stall_cnt !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_stall_cnt got %0d want 2", o_stall_cnt);
    end
    // Assert reset mid-wait with a forwarding match present.
    rst = 1'b1;
    i_rd_m = 5'd3; i_reg_wr_m = 1'b1; i_rs1_e = 5'd3; i_branch_taken_e = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (ctl !== CTL_IDLE) begin
        miscompares++;
        $display("[TB] FAIL reset_ctl cycle %0d got %b want %b", c, ctl, CTL_IDLE);
      end
      vectors++;
      if (o_fwd_a_e !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reset_fwd_a cycle %0d got %b want 00", c, o_fwd_a_e);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== CTL_IDLE) begin
      miscompares++;
      $display("[TB] FAIL post_reset_ctl got %b want %b", ctl, CTL_IDLE);
    end
    vectors++;
    if (o_stall_cnt !== 16'd0 || o_flush_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_cnt got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt);
    end
    expStall = 0;
    expFlush = 0;
  endtask

  task automatic test_load_use();
    idle_inputs();
    i_mem_rd_e = 1'b1; i_reg_wr_e = 1'b1; i_rd_e = 5'd5; i_rs1_d = 5'd5;
    #1;
    vectors++;
    if (ctl !== CTL_LU) begin
      miscompares++;
      $display("[TB] FAIL load_use_rs1 got %b want %b", ctl, CTL_LU);
    end
    tick();
    expStall++;
    i_rs1_d = 5'd1; i_rs2_d = 5'd5;
    #1;
    vectors++;
    if (ctl !== CTL_LU) begin
      miscompares++;
      $display("[TB] FAIL load_use_rs2 got %b want %b", ctl, CTL_LU);
    end
    tick();
    expStall++;
    i_rd_e = 5'd0; i_rs1_d = 5'd0; i_rs2_d = 5'd0;
    #1;
    vectors++;
    if (ctl !== CTL_IDLE) begin
      miscompares++;
      $display("[TB] FAIL load_use_x0 got %b want %b", ctl, CTL_IDLE);
    end
    tick();
    vectors++;
    if (o_stall_cnt !== CNT_W'(expStall)) begin
      miscompares++;
      $display("[TB] FAIL load_use_stall_cnt got %0d want %0d", o_stall_cnt, expStall);
    end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    i_rd_m = 5'd7; i_rd_w = 5'd7; i_reg_wr_m = 1'b1; i_reg_wr_w = 1'b1;
    i_rs1_e = 5'd7; i_rs2_e = 5'd7;
    #1;
    vectors++;
    if (o_fwd_a_e !== 2'b10 || o_fwd_b_e !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL fwd_mem got %b/%b want 10/10", o_fwd_a_e, o_fwd_b_e);
    end
    i_reg_wr_m = 1'b0;
    #1;
    vectors++;
    if (o_fwd_a_e !== 2'b01 || o_fwd_b_e !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL fwd_wb got %b/%b want 01/01", o_fwd_a_e, o_fwd_b_e);
    end
    i_reg_wr_m = 1'b1; i_rd_m = 5'd0; i_rd_w = 5'd0; i_rs1_e = 5'd0; i_rs2_e = 5'd0;
    #1;
    vectors++;
    if (o_fwd_a_e !== 2'b00 || o_fwd_b_e !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL fwd_x0 got %b/%b want 00/00", o_fwd_a_e, o_fwd_b_e);
    end
    i_rd_m = 5'd3; i_rd_w = 5'd7; i_rs1_e = 5'd7; i_rs2_e = 5'd3;
    #1;
    vectors++;
    if (o_fwd_a_e !== 2'b01 || o_fwd_b_e !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL fwd_mixed got %b/%b want 01/10", o_fwd_a_e, o_fwd_b_e);
    end
    tick();
  endtask

  task automatic test_redirect_over_lu();
    idle_inputs();
    i_mem_rd_e = 1'b1; i_reg_wr_e = 1'b1; i_rd_e = 5'd9; i_rs2_d = 5'd9;
    i_branch_taken_e = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_REDIR) begin
      miscompares++;
      $display("[TB] FAIL redirect_beats_lu got %b want %b", ctl, CTL_REDIR);
    end
    tick();
    expFlush++;
    idle_inputs();
    #1;
    vectors++;
    if (o_flush_cnt !== CNT_W'(expFlush) || o_stall_cnt !== CNT_W'(expStall)) begin
      miscompares++;
      $display("[TB] FAIL redirect_cnt got %0d/%0d want %0d/%0d",
               o_flush_cnt, o_stall_cnt, expFlush, expStall);
    end
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    i_dmem_req_m = 1'b1; i_dmem_ready = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_IDLE) begin
      miscompares++;
      $display("[TB] FAIL mem_ready_first_cycle got %b want %b", ctl, CTL_IDLE);
    end
    tick();
    i_dmem_ready = 1'b0;
    i_rd_w = 5'd4; i_reg_wr_w = 1'b1; i_rs2_e = 5'd4;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (ctl !== CTL_WAIT) begin
        miscompares++;
        $display("[TB] FAIL mem_wait cycle %0d got %b want %b", c, ctl, CTL_WAIT);
      end
      tick();
      expStall++;
    end
    vectors++;
    if (o_fwd_b_e !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL fwd_during_wait got %b want 01", o_fwd_b_e);
    end
    i_dmem_ready = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_IDLE) begin
      miscompares++;
      $display("[TB] FAIL mem_wait_release got %b want %b", ctl, CTL_IDLE);
    end
    tick();
    idle_inputs();
    i_branch_taken_e = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_REDIR) begin
      miscompares++;
      $display("[TB] FAIL back_in_run got %b want %b", ctl, CTL_REDIR);
    end
    i_branch_taken_e = 1'b0;
    #1;
    vectors++;
    if (o_stall_cnt !== CNT_W'(expStall)) begin
      miscompares++;
      $display("[TB] FAIL mem_wait_stall_cnt got %0d want %0d", o_stall_cnt, expStall);
    end
    tick();
  endtask

  task automatic test_pending_redirect();
    idle_inputs();
    i_dmem_req_m = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_branch_taken_e = (c == 1);
      #1;
      vectors++;
      if (ctl !== CTL_WAIT) begin
        miscompares++;
        $display("[TB] FAIL pend_wait cycle %0d got %b want %b", c, ctl, CTL_WAIT);
      end
      tick();
      expStall++;
    end
    i_branch_taken_e = 1'b0; i_dmem_ready = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_REDIR) begin
      miscompares++;
      $display("[TB] FAIL pend_redirect got %b want %b", ctl, CTL_REDIR);
    end
    tick();
    expFlush++;
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== CTL_IDLE) begin
      miscompares++;
      $display("[TB] FAIL pend_cleared got %b want %b", ctl, CTL_IDLE);
    end
    vectors++;
    if (o_flush_cnt !== CNT_W'(expFlush) || o_stall_cnt !== CNT_W'(expStall)) begin
      miscompares++;
      $display("[TB] FAIL pend_cnt got %0d/%0d want %0d/%0d",
               o_flush_cnt, o_stall_cnt, expFlush, expStall);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    i_mem_rd_e = 1'b1; i_reg_wr_e = 1'b1; i_rd_e = 5'd12; i_rs1_d = 5'd12;
    #1;
    vectors++;
    if (ctl !== CTL_LU) begin
      miscompares++;
      $display("[TB] FAIL b2b_lu got %b want %b", ctl, CTL_LU);
    end
    tick();
    expStall++;
    idle_inputs();
    i_branch_taken_e = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_REDIR) begin
      miscompares++;
      $display("[TB] FAIL b2b_branch got %b want %b", ctl, CTL_REDIR);
    end
    tick();
    expFlush++;
    idle_inputs();
    #1;
    vectors++;
    if (o_flush_cnt !== CNT_W'(expFlush) || o_stall_cnt !== CNT_W'(expStall)) begin
      miscompares++;
      $display("[TB] FAIL b2b_cnt got %0d/%0d want %0d/%0d",
               o_flush_cnt, o_stall_cnt, expFlush, expStall);
    end
    vectors++;
    if (ctl === CTL_BROK) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle got %b want %b", ctl, CTL_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_redirect_over_lu();
    test_mem_wait();
    test_pending_redirect();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It generates stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three hazard classes: load-use, taken branch/jump resolved in EX, and multi-cycle data-memory wait. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters
REG_AW, 5, register-address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rs1_d, rs2_d  in  REG_AW  source registers of the instruction in ID
rs1_e, rs2_e  in  REG_AW  source registers of the instruction in EX
rd_e  in  REG_AW  destination register in EX
reg_wr_e  in  1  instruction in EX writes rd
mem_rd_e  in  1  instruction in EX is a load
rd_m, rd_w  in  REG_AW  destination registers in MEM and WB
reg_wr_m, reg_wr_w  in  1  write enables in MEM and WB
branch_taken_e  in  1  branch/jump in EX redirects the PC this cycle
dmem_req_m  in  1  MEM-stage load/store is issuing a request
dmem_ready  in  1  data memory completes the request this cycle
stall_f  out  1  hold the PC
stall_d  out  1  hold IF/ID
flush_d  out  1  IF/ID loads NOP 32'h00000013
stall_e, stall_m  out  1  hold ID/EX and EX/MEM
flush_e  out  1  ID/EX loads a bubble (all control bits 0)
flush_w  out  1  MEM/WB loads a bubble
redirect_ok  out  1  PC mux may take the branch target this cycle
fwd_a_e, fwd_b_e  out  2  EX operand select: 00 register file, 01 WB, 10 MEM
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Control outputs are combinational from the inputs, state and pend_redir. Counters and FSM state are registered.
- Reset values:
  - state=RUN, pend_redir=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, all stall and flush outputs are 0, redirect_ok=0, fwd_*=00.
  - Reset overrides everything, including mid-MEM_WAIT.
- Forwarding:
  - fwd_a_e=10 if reg_wr_m && rd_m!=0 && rd_m==rs1_e.
  - Otherwise 01 if reg_wr_w && rd_w!=0 && rd_w==rs1_e.
  - Otherwise 00.
  - fwd_b_e follows the same rule using rs2_e.
  - Forwarding is active in all states; x0 is never forwarded.
- Load-use: lu = mem_rd_e && reg_wr_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- FSM states: RUN, MEM_WAIT.
  - RUN to MEM_WAIT when dmem_req_m && !dmem_ready.
  - MEM_WAIT to RUN when dmem_ready.
  - A request that completes in its first cycle (dmem_ready=1) causes no wait.
- Memory wait is active when (RUN && dmem_req_m && !dmem_ready) or (MEM_WAIT && !dmem_ready).
  - Outputs: stall_f, stall_d, stall_e, stall_m = 1; flush_w=1; all other flushes 0; redirect_ok=0.
  - Memory wait has the highest priority.
- pend_redir:
  - Set if branch_taken_e=1 during a memory-wait cycle; EX is frozen, so the branch is held.
  - On the first non-wait cycle with pend_redir=1, perform the redirect action and clear pend_redir.
- Redirect action, when (branch_taken_e || pend_redir) and there is no memory wait:
  - flush_d=1, flush_e=1, redirect_ok=1, all stalls 0.
  - Redirect beats load-use, because the load-use consumer is on the wrong path.
- Load-use action, when there is no memory wait and no redirect:
  - stall_f=1, stall_d=1, flush_e=1, redirect_ok=0.
  - Lasts exactly 1 cycle per occurrence.
- Otherwise all stall/flush outputs are 0, and redirect_ok=branch_taken_e.
- Counters:
  - stall_cnt increments on every cycle with stall_f=1.
  - flush_cnt increments on every cycle with flush_d=1.
  - Both saturate at all-ones.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - hz_state_t enum (RUN, MEM_WAIT)
  - localparam NOP_INSN=32'h00000013
- Sub-module fwd_unit: purely combinational forwarding for one operand, instantiated twice.

Test Plan:
- rst=1 for 2 cycles mid-MEM_WAIT, then released -> state=RUN, all controls 0, counters 0.
- mem_rd_e=1, reg_wr_e=1, rd_e=5, rs1_d=5 -> one cycle of stall_f=stall_d=flush_e=1, stall_cnt=1; with rd_e=0 -> no stall.
- rd_m=7, rd_w=7, both write, rs1_e=7, rs2_e=7 -> fwd_a_e=fwd_b_e=10; reg_wr_m=0 -> 01; rd_m=rd_w=0 -> 00.
- branch_taken_e=1 together with a load-use condition -> flush_d=flush_e=1, redirect_ok=1, no stall; flush_cnt increments by 1.
- dmem_req_m=1, dmem_ready low for 3 cycles -> stall_f, stall_d, stall_e, stall_m, flush_w high for 3 cycles, stall_cnt=3, returns to RUN on the cycle dmem_ready=1.
- branch_taken_e=1 during wait cycle 2 -> no flush during the wait; flush_d=flush_e=redirect_ok=1 in the first cycle after dmem_ready, then pend_redir=0.
